// File: rtl/alu_seq_ctrl_if.sv
// alu_seq_ctrl_if: request/response handshakes, shared-bus signals and ALU strobes of the ALU sequencer
interface alu_seq_ctrl_if #(parameter int W = 32);
   logic         req_valid;
   logic         req_ready;
   logic [3:0]   req_op;
   logic [W-1:0] req_a;
   logic [W-1:0] req_b;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [W-1:0] rsp_data;
   logic         rsp_err;
   logic         bus_req;
   logic         bus_gnt;
   logic         bus_oe;
   logic [W-1:0] bus_drv;
   logic [W-1:0] bus_in;
   logic         a_in;
   logic         c_in;
   logic         c_out;
   logic         add;
   logic         sub;
   logic         a_and_b;
   logic         a_or_b;
   logic         shr;
   logic         shra;
   logic         shl;
   logic         not_a;
   logic         c_eq_b;
   logic         inc_4;
   modport master (
      input  req_valid, req_op, req_a, req_b, rsp_ready, bus_gnt, bus_in,
      output req_ready, rsp_valid, rsp_data, rsp_err, bus_req, bus_oe, bus_drv,
             a_in, c_in, c_out, add, sub, a_and_b, a_or_b, shr, shra, shl, not_a, c_eq_b, inc_4
   );
   modport slave (
      output req_valid, req_op, req_a, req_b, rsp_ready, bus_gnt, bus_in,
      input  req_ready, rsp_valid, rsp_data, rsp_err, bus_req, bus_oe, bus_drv,
             a_in, c_in, c_out, add, sub, a_and_b, a_or_b, shr, shra, shl, not_a, c_eq_b, inc_4
   );
endinterface

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: steps the single-bus ALU through load-A, execute, latch-C and read-C phases
// for one request at a time and returns the result captured from the shared bus.
module alu_seq_ctrl #(parameter int W = 32) (
   input  logic clk,
   input  logic reset_n,
   alu_seq_ctrl_if.master sif
);
   typedef enum logic [2:0] {IDLE, LOAD_A, EXEC, LATCH, READ_C, RESP} state_t;
   state_t       state_q, state_d;
   logic [3:0]   op_q;
   logic [W-1:0] a_q, b_q, data_q;
   logic         err_q;
   logic         legal, accept, busy, go, opdrv;
   logic [9:0]   sel;
   assign legal  = sif.req_op <= 4'd9;
   assign accept = sif.req_valid && state_q == IDLE;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (sif.req_valid) state_d = !legal ? RESP : sif.req_op == 4'd8 ? EXEC : LOAD_A;
         LOAD_A:  if (sif.bus_gnt) state_d = EXEC;
         EXEC:    if (sif.bus_gnt) state_d = LATCH;
         LATCH:   if (sif.bus_gnt) state_d = READ_C;
         READ_C:  if (sif.bus_gnt) state_d = RESP;
         RESP:    if (sif.rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   // every strobe is a decode of the registered state qualified by the grant, so reset drops them at once
   always_comb begin
      busy          = state_q inside {LOAD_A, EXEC, LATCH, READ_C};
      go            = busy && sif.bus_gnt;
      opdrv         = go && state_q inside {EXEC, LATCH};
      sel           = opdrv ? 10'd1 << op_q : '0;
      sif.req_ready = state_q == IDLE;
      sif.rsp_valid = state_q == RESP;
      sif.rsp_data  = data_q;
      sif.rsp_err   = err_q;
      sif.bus_req   = busy;
      sif.a_in      = go && state_q == LOAD_A;
      sif.c_in      = go && state_q == LATCH;
      sif.c_out     = go && state_q == READ_C;
      sif.bus_oe    = sif.a_in || opdrv;
      sif.bus_drv   = sif.a_in ? a_q : (opdrv && op_q != 4'd7 && op_q != 4'd9) ? b_q : '0;
      sif.add       = sel[0];
      sif.sub       = sel[1];
      sif.a_and_b   = sel[2];
      sif.a_or_b    = sel[3];
      sif.shr       = sel[4];
      sif.shra      = sel[5];
      sif.shl       = sel[6];
      sif.not_a     = sel[7];
      sif.c_eq_b    = sel[8];
      sif.inc_4     = sel[9];
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         op_q   <= '0;
         a_q    <= '0;
         b_q    <= '0;
         data_q <= '0;
         err_q  <= 1'b0;
      end else begin
         if (accept) begin
            op_q  <= sif.req_op;
            a_q   <= sif.req_a;
            b_q   <= sif.req_b;
            err_q <= !legal;
            if (!legal) data_q <= '0;
         end
         if (sif.c_out) data_q <= sif.bus_in;
      end
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: randomized and directed transactions against a behavioural ALU/bus model.
module tb_alu_seq_ctrl;
   logic clk = 0, reset_n = 0;
   int tests = 0, fails = 0;
   logic [31:0] alu_a = 0, alu_c = 0, junk = 0, emu, bus_val;
   logic [9:0] ops;
   alu_seq_ctrl_if #(.W(32)) sif();
   alu_seq_ctrl #(.W(32)) dut (.clk(clk), .reset_n(reset_n), .sif(sif));
   always #5 clk = ~clk;
   assign ops = {sif.inc_4, sif.c_eq_b, sif.not_a, sif.shl, sif.shra, sif.shr, sif.a_or_b, sif.a_and_b, sif.sub, sif.add};
   assign bus_val = sif.bus_oe ? sif.bus_drv : sif.c_out ? alu_c : junk;
   assign sif.bus_in = bus_val;
   always_comb begin
      emu = 32'h0;
      if (sif.add)     emu = alu_a + bus_val;
      if (sif.sub)     emu = alu_a - bus_val;
      if (sif.a_and_b) emu = alu_a & bus_val;
      if (sif.a_or_b)  emu = alu_a | bus_val;
      if (sif.shr)     emu = alu_a >> bus_val;
      if (sif.shra)    emu = $unsigned($signed(alu_a) >>> bus_val);
      if (sif.shl)     emu = alu_a << bus_val;
      if (sif.not_a)   emu = ~alu_a;
      if (sif.c_eq_b)  emu = bus_val;
      if (sif.inc_4)   emu = alu_a + 32'd4;
   end
   always @(posedge clk) begin
      junk <= $urandom;
      if (sif.a_in) alu_a <= bus_val;
      if (sif.c_in) alu_c <= emu;
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask
   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      logic signed [31:0] sa;
      sa = a;
      case (op)
         4'd0: return a + b;
         4'd1: return a - b;
         4'd2: return a & b;
         4'd3: return a | b;
         4'd4: return a >> b;
         4'd5: return $unsigned(sa >>> b);
         4'd6: return a << b;
         4'd7: return ~a;
         4'd8: return b;
         4'd9: return a + 32'd4;
         default: return 32'h0;
      endcase
   endfunction
   always @(negedge clk) if (reset_n) begin
      chk("onehot", 32'($countones(ops) <= 1), 1);
      chk("oe_cout", 32'(sif.bus_oe & sif.c_out), 0);
      chk("ac_excl", 32'($countones({sif.a_in, sif.c_in, sif.c_out}) <= 1), 1);
      chk("gnt_gate", 32'(!sif.bus_gnt && (|ops || sif.a_in || sif.c_in || sif.c_out || sif.bus_oe)), 0);
   end
   task automatic txn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int gmode, input int hold);
      int n, k, na, nc, nco, nreq, nop, cpos;
      logic lg;
      int base;
      logic [31:0] d;
      lg = op <= 4'd9;
      base = !lg ? 1 : op == 4'd8 ? 4 : 5;
      k = 0; na = 0; nc = 0; nco = 0; nreq = 0; nop = 0; cpos = 0;
      @(posedge clk) #1;
      sif.req_op = op; sif.req_a = a; sif.req_b = b; sif.req_valid = 1;
      @(negedge clk) chk("req_ready", 32'(sif.req_ready), 1);
      @(posedge clk) #1;
      sif.req_valid = 0; sif.req_op = 4'($urandom); sif.req_a = $urandom; sif.req_b = $urandom;
      for (n = 1; n <= 200; n++) begin
         sif.bus_gnt = gmode == 0 ? 1'b1 : gmode == 1 ? ($urandom % 3 != 0) : !(n >= 2 && n <= 4);
         @(negedge clk);
         if (sif.rsp_valid) break;
         if (!sif.bus_gnt) k++;
         na += 32'(sif.a_in); nc += 32'(sif.c_in); nreq += 32'(sif.bus_req);
         nop += $countones(ops);
         if (lg && ops[op]) nop += 100;
         if (sif.c_out) begin nco++; cpos = n; end
         @(posedge clk) #1;
      end
      chk("timeout", 32'(n > 200), 0);
      if (n > 200) return;
      chk("latency", n, base + k);
      chk("bus_req", nreq, n - 1);
      chk("a_in_cnt", na, (lg && op != 4'd8) ? 1 : 0);
      chk("op_strobes", nop, lg ? 202 : 0);
      chk("c_in_cnt", nc, lg ? 1 : 0);
      chk("c_out_cnt", nco, lg ? 1 : 0);
      if (gmode == 0) chk("c_out_pos", cpos, lg ? base - 1 : 0);
      chk("data", sif.rsp_data, lg ? ref_alu(op, a, b) : 32'h0);
      chk("err", 32'(sif.rsp_err), 32'(!lg));
      d = sif.rsp_data;
      for (int h = 0; h < hold; h++) begin
         @(posedge clk) #1;
         @(negedge clk);
         chk("hold_valid", 32'(sif.rsp_valid), 1);
         chk("hold_data", sif.rsp_data, d);
         chk("hold_err", 32'(sif.rsp_err), 32'(!lg));
         chk("hold_req_ready", 32'(sif.req_ready), 0);
      end
      sif.rsp_ready = 1;
      @(posedge clk) #1 sif.rsp_ready = 0;
      @(negedge clk);
      chk("rsp_done", 32'(sif.rsp_valid), 0);
      chk("idle_ready", 32'(sif.req_ready), 1);
   endtask
   initial begin
      logic [3:0] op;
      logic [31:0] b;
      sif.req_valid = 0; sif.req_op = 0; sif.req_a = 0; sif.req_b = 0; sif.rsp_ready = 0; sif.bus_gnt = 1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", 32'(sif.rsp_valid), 0);
      chk("rst_err", 32'(sif.rsp_err), 0);
      chk("rst_bus_req", 32'(sif.bus_req), 0);
      chk("rst_oe", 32'(sif.bus_oe), 0);
      chk("rst_strobes", 32'({ops, sif.a_in, sif.c_in, sif.c_out}), 0);
      chk("rst_data", sif.rsp_data, 0);
      chk("rst_drv", sif.bus_drv, 0);
      @(posedge clk) #1 reset_n = 1;
      @(negedge clk) chk("rst_ready", 32'(sif.req_ready), 1);
      txn(4'd0, 32'd5, 32'd7, 0, 0);
      txn(4'd1, 32'd3, 32'd5, 0, 0);
      txn(4'd5, 32'h8000_0000, 32'd4, 0, 1);
      txn(4'd8, 32'h1234_5678, 32'hDEAD_BEEF, 0, 0);
      txn(4'd12, 32'h1111, 32'h2222, 0, 0);
      txn(4'd2, 32'h0000_F0F0, 32'h0000_FF00, 2, 4);
      @(posedge clk) #1;
      sif.req_op = 4'd0; sif.req_a = 32'd9; sif.req_b = 32'd9; sif.req_valid = 1; sif.bus_gnt = 1;
      @(posedge clk) #1 sif.req_valid = 0;
      repeat (2) @(posedge clk);
      @(negedge clk) chk("pre_rst_latch", 32'(sif.c_in), 1);
      #1 reset_n = 0;
      #1 chk("rst_abort", 32'({ops, sif.a_in, sif.c_in, sif.c_out, sif.bus_oe, sif.bus_req}), 0);
      repeat (2) @(posedge clk);
      #3 reset_n = 1;
      @(negedge clk);
      chk("post_rst_ready", 32'(sif.req_ready), 1);
      chk("post_rst_valid", 32'(sif.rsp_valid), 0);
      txn(4'd0, 32'd1, 32'd1, 0, 0);
      for (int i = 0; i < 60; i++) begin
         op = ($urandom % 5 == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
         b = ($urandom % 2) ? $urandom_range(0, 40) : $urandom;
         txn(op, $urandom, b, $urandom_range(0, 2), $urandom_range(0, 3));
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Sequencer for the single-bus ALU (A register, result latch, C register, one-hot operation strobes). It accepts an operation request over a valid/ready handshake and requests the shared CPU bus. It then steps the ALU through load-A, execute, latch-C and read-C phases, captures the result from the bus and returns it over a second valid/ready handshake. It sits between instruction control and the ALU; the bus is shared with other masters under an external grant.

## Interface
- `W`, default 32: datapath/bus width; must match the ALU.
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when high with `req_valid`.
- `req_op`  in  4  opcode: 0 add, 1 sub, 2 and, 3 or, 4 shr, 5 shra, 6 shl, 7 not_a, 8 c_eq_b, 9 inc_4, 10–15 illegal.
- `req_a`, `req_b`  in  W  operands.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts result.
- `rsp_data`  out  W  result.
- `rsp_err`  out  1  illegal opcode flag.
- `bus_req`  out  1  bus request to bus arbiter.
- `bus_gnt`  in  1  bus granted this cycle.
- `bus_oe`  out  1  drive `bus_drv` onto the bus.
- `bus_drv`  out  W  value to drive.
- `bus_in`  in  W  current bus value.
- `a_in`, `c_in`, `c_out`, `add`, `sub`, `a_and_b`, `a_or_b`, `shr`, `shra`, `shl`, `not_a`, `c_eq_b`, `inc_4`  out  1 each  ALU control strobes.

## Operation
- States: IDLE, LOAD_A, EXEC, LATCH, READ_C, RESP.
- IDLE:
  - `req_ready`=1.
  - On accept: latch op, a and b.
  - Legal op 8 → EXEC; other legal op → LOAD_A.
  - Illegal op → RESP with `rsp_err`=1, `rsp_data`=0, no bus activity.
- `bus_req`=1 in LOAD_A, EXEC, LATCH and READ_C.
- Gating in those states: all strobes and `bus_oe` are 0 and the state holds while `bus_gnt`=0.
- LOAD_A, gnt=1: `bus_oe`=1, `bus_drv`=a, `a_in`=1 → EXEC.
- EXEC, gnt=1: `bus_oe`=1, `bus_drv`=b (0 for ops 7 and 9), the selected op strobe=1 → LATCH.
- LATCH, gnt=1: same bus drive and op strobe as EXEC, plus `c_in`=1 → READ_C.
- READ_C, gnt=1:
  - `bus_oe`=0, `c_out`=1.
  - `bus_in` is registered into `rsp_data` at the end of the cycle → RESP.
- RESP:
  - `rsp_valid`=1; `rsp_data` and `rsp_err` are stable.
  - On `rsp_ready`=1 → IDLE.
- Strobes and `bus_oe` are combinational decodes of the registered state, ANDed with `bus_gnt`.
- Invariants:
  - At most one op strobe high.
  - `bus_oe` and `c_out` never high together.
  - `a_in`, `c_in` and `c_out` are mutually exclusive.
- Operands are passed unmodified; the ALU uses the full b value as the shift amount.
- `rsp_err` is cleared on each legal accept.

## Timing
- Reset (async assert, sync release):
  - State IDLE; `req_ready`=1 after release.
  - `rsp_valid`, `rsp_err`, `bus_req`, `bus_oe` and all strobes are 0.
  - `rsp_data` and `bus_drv` are 0.
- Reset mid-operation aborts immediately: strobes and `bus_oe` drop asynchronously and the transaction is lost.
- Latency with `bus_gnt` held high, counted from the accept edge to the first `rsp_valid` cycle:
  - Binary ops and ops 7 and 9: 5 cycles (LOAD_A, EXEC, LATCH, READ_C, RESP).
  - Op 8: 4 cycles.
  - Illegal op: 1 cycle.
- Each low cycle of `bus_gnt` adds exactly one cycle. A phase is never half-executed.
- No pipelining: the next accept is possible no earlier than the cycle after the RESP handshake.
- Minimum issue interval for a binary op is 6 cycles.
- `rsp_data` and `rsp_err` hold while `rsp_valid`=1 and `rsp_ready`=0.

## Test plan
- Add: op 0, a=5, b=7, gnt=1 → `a_in` in cycle 1; `add` in cycles 2–3; `c_in` in cycle 3; `c_out` in cycle 4; `rsp_valid` in cycle 5 with `rsp_data`=12 and `rsp_err`=0.
- Sub and shift: op 1, a=3, b=5 → 0xFFFFFFFE. Op 5, a=0x80000000, b=4 → 0xF8000000.
- Op 8 (c_eq_b), b=0xDEADBEEF → no `a_in` pulse; `rsp_valid` 4 cycles after accept with 0xDEADBEEF.
- Op 12 (illegal) → `rsp_valid` next cycle, `rsp_err`=1, `rsp_data`=0; `bus_req` and all strobes stay 0.
- Stall and backpressure:
  - Op 2, a=0xF0F0, b=0xFF00, `bus_gnt` low for 3 cycles during EXEC → latency 8, result 0xF000, no strobes while gnt=0.
  - `rsp_ready` low for 4 cycles → `rsp_data` stable and `req_ready`=0 throughout.
- Reset pulse during LATCH → strobes 0 within the reset assertion; after release `req_ready`=1 and `rsp_valid`=0; a following add 1+1 returns 2.
